// File: rtl/svsd_pkg.sv
// Shared definitions for the seven-segment scan driver: FSM state type,
// hex-to-segment table (active-high, bit0=a .. bit6=g) and polarity helper.
package svsd_pkg;

  typedef enum logic {
    BLANK = 1'b0,
    DRIVE = 1'b1
  } state_t;

  // Standard hex glyphs 0..F, segment on = 1.
  localparam logic [6:0] SEG_TABLE [16] = '{
    7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
    7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71
  };

  // All segments dark, expressed active-high.
  localparam logic [6:0] SEG_OFF = 7'h00;

  // Convert an active-high segment pattern to the pin polarity.
  function automatic logic [6:0] seg_apply(input logic [6:0] pat, input bit active_low);
    return active_low ? ~pat : pat;
  endfunction

endpackage

// File: rtl/svsd_hex_decoder.sv
// Combinational nibble to seven-segment pattern lookup (active-high).
module svsd_hex_decoder
  import svsd_pkg::*;
(
  input  logic [3:0] nibble,
  output logic [6:0] pattern
);

  assign pattern = SEG_TABLE[nibble];

endmodule

// File: rtl/svsd_scan_driver.sv
// Multiplexed seven-segment scan driver. Each digit slot of DIGIT_TICKS
// cycles starts with BLANK_TICKS all-off cycles to stop ghosting, then drives
// one digit. The display word is copied into a shadow register only when the
// last digit's slot ends, so a frame never mixes two words.
// Optional: define SVSD_LEADING_ZERO_BLANK_EN to dark leading-zero digits.
// Reset release is expected to be synchronised to clk_clk upstream.
module svsd_scan_driver
  import svsd_pkg::*;
#(
  parameter int NUM_DIGITS     = 8,
  parameter int CLK_HZ         = 50000000,
  parameter int SCAN_HZ        = 1000,
  parameter int BLANK_TICKS    = 16,
  parameter bit SEG_ACTIVE_LOW = 1'b1,
  parameter bit DIG_ACTIVE_LOW = 1'b1
) (
  input  logic                  clk_clk,
  input  logic                  reset_reset_n,
  input  logic [31:0]           svsd_word,
  output logic [6:0]            seg,
  output logic [NUM_DIGITS-1:0] digit_sel,
  output logic                  frame_start
);

  localparam int DIGIT_TICKS = CLK_HZ / SCAN_HZ;
  localparam int TICK_W      = (DIGIT_TICKS > 2) ? $clog2(DIGIT_TICKS) : 1;
  localparam int IDX_W       = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
  localparam int SHADOW_W    = 4 * NUM_DIGITS;

  localparam logic [TICK_W-1:0] BLANK_LAST = TICK_W'(BLANK_TICKS - 1);
  localparam logic [TICK_W-1:0] SLOT_LAST  = TICK_W'(DIGIT_TICKS - 1);
  localparam logic [IDX_W-1:0]  IDX_LAST   = IDX_W'(NUM_DIGITS - 1);

  localparam logic [6:0]            SEG_IDLE = seg_apply(SEG_OFF, SEG_ACTIVE_LOW);
  localparam logic [NUM_DIGITS-1:0] SEL_IDLE = DIG_ACTIVE_LOW ? '1 : '0;

  generate
    if (BLANK_TICKS < 1 || BLANK_TICKS >= DIGIT_TICKS) begin : g_bad_blank
      $error("BLANK_TICKS must be >= 1 and < CLK_HZ/SCAN_HZ");
    end
    if (NUM_DIGITS < 1 || NUM_DIGITS > 8) begin : g_bad_digits
      $error("NUM_DIGITS must be in 1..8");
    end
  endgenerate

  state_t                state, state_next;
  logic [TICK_W-1:0]     tick_cnt;
  logic [IDX_W-1:0]      idx;
  logic [SHADOW_W-1:0]   shadow;
  logic                  slot_end;
  logic                  wrap;
  logic [3:0]            nibble;
  logic [6:0]            pattern;
  logic [6:0]            shown;
  logic [NUM_DIGITS-1:0] onehot;
  logic [6:0]            seg_next;
  logic [NUM_DIGITS-1:0] sel_next;

  assign slot_end = (state == DRIVE) && (tick_cnt == SLOT_LAST);
  assign wrap     = slot_end && (idx == IDX_LAST);
  assign nibble   = shadow[4*idx +: 4];
  assign onehot   = NUM_DIGITS'(1) << idx;

  svsd_hex_decoder u_dec (
    .nibble  (nibble),
    .pattern (pattern)
  );

  // FSM state register
  always_ff @(posedge clk_clk or negedge reset_reset_n) begin
    if (!reset_reset_n) state <= BLANK;
    else                state <= state_next;
  end

  // FSM next state: blank lead-in, then drive until the slot ends
  always_comb begin
    state_next = state;
    case (state)
      BLANK:   if (tick_cnt == BLANK_LAST) state_next = DRIVE;
      DRIVE:   if (slot_end) state_next = BLANK;
      default: state_next = BLANK;
    endcase
  end

  // Slot tick counter and digit index; index wraps after the last digit
  always_ff @(posedge clk_clk or negedge reset_reset_n) begin
    if (!reset_reset_n) begin
      tick_cnt <= '0;
      idx      <= '0;
    end else if (slot_end) begin
      tick_cnt <= '0;
      idx      <= wrap ? '0 : idx + 1'b1;
    end else begin
      tick_cnt <= tick_cnt + 1'b1;
    end
  end

  // Shadow word load and frame pulse at the frame boundary
  always_ff @(posedge clk_clk or negedge reset_reset_n) begin
    if (!reset_reset_n) begin
      shadow      <= '0;
      frame_start <= 1'b0;
    end else begin
      frame_start <= wrap;
      if (wrap) shadow <= svsd_word[SHADOW_W-1:0];
    end
  end

`ifdef SVSD_LEADING_ZERO_BLANK_EN
  // Reset shadow is all zero, so every digit except digit 0 starts dark.
  localparam logic [NUM_DIGITS-1:0] MASK_RST = ~NUM_DIGITS'(1);

  logic [NUM_DIGITS-1:0] blank_mask, blank_mask_next;

  // Leading-zero mask for the incoming word: digit i>0 dark when it and all above are zero
  always_comb begin
    blank_mask_next = '0;
    for (int i = 1; i < NUM_DIGITS; i++) begin
      blank_mask_next[i] = ((svsd_word[SHADOW_W-1:0] >> (4 * i)) == '0);
    end
  end

  // Mask is captured together with the shadow word
  always_ff @(posedge clk_clk or negedge reset_reset_n) begin
    if (!reset_reset_n) blank_mask <= MASK_RST;
    else if (wrap)      blank_mask <= blank_mask_next;
  end

  assign shown = blank_mask[idx] ? SEG_OFF : pattern;
`else
  assign shown = pattern;
`endif

  // FSM outputs: everything off in BLANK, selected digit and its glyph in DRIVE
  always_comb begin
    seg_next = SEG_IDLE;
    sel_next = SEL_IDLE;
    if (state == DRIVE) begin
      seg_next = seg_apply(shown, SEG_ACTIVE_LOW);
      sel_next = DIG_ACTIVE_LOW ? ~onehot : onehot;
    end
  end

  // Registered pins so the display never sees combinational glitches
  always_ff @(posedge clk_clk or negedge reset_reset_n) begin
    if (!reset_reset_n) begin
      seg       <= SEG_IDLE;
      digit_sel <= SEL_IDLE;
    end else begin
      seg       <= seg_next;
      digit_sel <= sel_next;
    end
  end

endmodule

// File: doc/svsd_scan_driver.md
Name: svsd_scan_driver

Overview:
- Physical-side consumer of the 32-bit seven-segment word that the processor writes to its display PIO.
- Holds the word as 8 hex nibbles and time-multiplexes them onto a common-segment, multi-digit display.
- Inserts inter-digit blanking to prevent ghosting.
- Double-buffers the word at frame boundaries so the display never tears.

Parameters:
- NUM_DIGITS, 8, digits scanned (1..8); digit i shows word[4i+3:4i], digit 0 rightmost
- CLK_HZ, 50000000, clk_clk frequency
- SCAN_HZ, 1000, per-digit refresh rate; DIGIT_TICKS = CLK_HZ/SCAN_HZ
- BLANK_TICKS, 16, cycles all-off at start of each digit slot; must be ≥1 and < DIGIT_TICKS (elaboration error otherwise)
- SEG_ACTIVE_LOW, 1, segment polarity
- DIG_ACTIVE_LOW, 1, digit-select polarity

Ports:
- clk_clk  in  1  system clock
- reset_reset_n  in  1  asynchronous, active-low reset
- svsd_word  in  32  display word from processor PIO; no strobe; may change any cycle
- seg  out  7  segments, bit0=a … bit6=g
- digit_sel  out  NUM_DIGITS  one-hot digit enable (polarity per DIG_ACTIVE_LOW)
- frame_start  out  1  one-cycle pulse when a new shadow word is loaded

Behaviour:
- Reset (async assert, sync release), all outputs registered:
  - state=BLANK, tick_cnt=0, idx=0, shadow=0
  - seg all inactive: 7'h7F if active-low, else 0
  - digit_sel all inactive
  - frame_start=0
- FSM states: BLANK, DRIVE. tick_cnt counts 0..DIGIT_TICKS-1 within each digit slot.
- BLANK: seg and digit_sel inactive. When tick_cnt==BLANK_TICKS-1, go to DRIVE.
- DRIVE:
  - digit_sel active for idx only.
  - seg = decode(shadow nibble idx).
  - When tick_cnt==DIGIT_TICKS-1: tick_cnt←0, idx advances, go to BLANK.
- Output timing: outputs reflect the new state on the clock after the transition. First active digit after reset is visible at cycle BLANK_TICKS+1.
- Slot wrap: when idx==NUM_DIGITS-1 ends its slot:
  - idx←0
  - shadow←svsd_word, sampled that exact cycle
  - frame_start=1 for that one cycle, coincident with the first BLANK cycle of the new frame.
- svsd_word changes mid-frame have no visible effect until the next wrap; shadow is the only source for decode.
- First frame after reset displays shadow=0. The first load happens at the end of frame 0.
- Decode: hex 0..F, standard patterns, active-high before polarity.
  - 0=3F 1=06 2=5B 3=4F 4=66 5=6D 6=7D 7=07 8=7F 9=6F A=77 b=7C C=39 d=5E E=79 F=71
  - SEG_ACTIVE_LOW inverts the pattern.
- Never more than one digit_sel bit active in any cycle, including across the DRIVE→BLANK edge.
- Reset asserted mid-slot: outputs go inactive immediately (asynchronous); the scan restarts from idx 0 after release.
- NUM_DIGITS=1: every slot is a wrap, so shadow reloads and frame_start pulses every DIGIT_TICKS cycles.

Optional Feature:
- Macro SVSD_LEADING_ZERO_BLANK_EN.
- Defined: any digit i>0 whose nibble and all higher nibbles (up to NUM_DIGITS-1) in shadow are zero shows all-inactive segments.
  - digit_sel still strobes normally, keeping timing uniform.
  - Digit 0 is never blanked.
  - The blank mask is computed from shadow at load time.
- Undefined: every digit always shows its decoded nibble; no mask logic is present.

Decomposition:
- Package svsd_pkg holds:
  - state enum (BLANK, DRIVE)
  - 16-entry segment constant table
  - SEG_OFF constant
  - a polarity-apply function
- One sub-module, svsd_hex_decoder: combinational nibble→7-bit pattern, used once on the selected nibble.
- Counter, FSM, shadow register and blank mask stay in the top.

Test Plan:
- Bench parameters: CLK_HZ=1000, SCAN_HZ=100 (DIGIT_TICKS=10), BLANK_TICKS=2, NUM_DIGITS=4, both polarities active-low.
- 1. Reset, then svsd_word=32'h0000_1234 → frame 0:
  - all digits seg=7'h40 (0 inverted)
  - frame_start pulses at cycle 40
  - frame 1: digit0 seg=~7'h66, digit1 ~7'h4F, digit2 ~7'h5B, digit3 ~7'h06
- 2. Blanking: in every slot, digit_sel==4'hF and seg==7'h7F for exactly 2 cycles, then one digit low for 8 cycles; never two bits low simultaneously.
- 3. Mid-frame change: word 0x0000_ABCD loaded; switch to 0x0000_EF01 at digit 2 of the next frame → digits 2,3 still show B,A; new values appear only after the next frame_start.
- 4. Async reset asserted at cycle 5 of a DRIVE phase → seg=7'h7F and digit_sel=4'hF within the same cycle, without a clock edge; after release, the first active digit is digit 0 at cycle 3.
- 5. With SVSD_LEADING_ZERO_BLANK_EN, word 0x0000_0050 → digits 3,2 inactive segments, digit1 shows 5, digit0 shows 0. Word 0 → only digit0 lit, showing 0. Without the macro, all four digits are lit.
- 6. Free-run 1000 frames with random words → frame_start period exactly 40 cycles; each displayed frame matches the word sampled at the preceding frame_start.
